// File: rtl/engine_sched_if.sv
// Scheduler bus: layer descriptor handshake (cmd_*) and engine pass handshake (eng_*).
// Modports:
//   master - descriptor source and compute engine (drives cmd_*, eng_done)
//   slave  - the scheduler (drives cmd_ready and the eng_* request/clear signals)
interface engine_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_stride;
  logic [7:0]  cmd_kernel;
  logic [7:0]  cmd_o_side;
  logic [15:0] cmd_o_channel;
  logic        eng_valid;
  logic [2:0]  eng_op;
  logic [7:0]  eng_kernel_size;
  logic [15:0] eng_stride2;
  logic        eng_done;
  logic        eng_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_stride, cmd_kernel, cmd_o_side, cmd_o_channel, eng_done,
    input  cmd_ready, eng_valid, eng_op, eng_kernel_size, eng_stride2, eng_clr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_stride, cmd_kernel, cmd_o_side, cmd_o_channel, eng_done,
    output cmd_ready, eng_valid, eng_op, eng_kernel_size, eng_stride2, eng_clr
  );
endinterface

// File: rtl/engine_sched.sv
// engine_sched: walks a layer descriptor as o_side rows x n_grp output-channel groups,
// issuing one engine pass per (row, group) and clearing the engine between passes.
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   bus         engine_sched_if.slave: descriptor handshake in, engine pass handshake out
//   row_idx     current output row
//   grp_idx     current output-channel group
//   layer_done  one-cycle pulse when all passes of a layer are complete
//   err         sticky error (illegal op or engine timeout); cleared only by reset
// Build option: define SCHED_TIMEOUT_EN to add a WAIT watchdog of TO_CYCLES cycles.
module engine_sched #(
  parameter int unsigned BURST     = 8,
  parameter int unsigned TO_CYCLES = 1048576
) (
  input  logic          clk,
  input  logic          rst,
  engine_sched_if.slave bus,
  output logic [7:0]    row_idx,
  output logic [15:0]   grp_idx,
  output logic          layer_done,
  output logic          err
);

  localparam logic [2:0] OpConv  = 3'd1;
  localparam logic [2:0] OpMpool = 3'd2;
  localparam logic [2:0] OpApool = 3'd3;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StClr, StDone} state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  stride_q, stride_d;
  logic [7:0]  kernel_q, kernel_d;
  logic [7:0]  o_side_q, o_side_d;
  logic [15:0] o_channel_q, o_channel_d;
  logic [7:0]  ksize_q, ksize_d;
  logic [15:0] stride2_q, stride2_d;
  logic [15:0] n_grp_q, n_grp_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] grp_q, grp_d;
  logic        err_q, err_d;

  logic        timeout;
  logic        abort;
  logic [16:0] ch_round;
  logic [16:0] ch_div;
  logic [15:0] n_grp_new;
  logic        op_legal;

  // ceil(o_channel / BURST); 17 bits so the round-up add cannot overflow
  assign ch_round  = {1'b0, o_channel_q} + 17'(BURST - 1);
  assign ch_div    = ch_round / 17'(BURST);
  assign n_grp_new = (op_q == OpConv) ? ch_div[15:0] : 16'd1;
  assign op_legal  = op_q inside {OpConv, OpMpool, OpApool};

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        abort_q, abort_d;

  assign timeout = (state_q == StWait) && !bus.eng_done && (to_cnt_q == 32'(TO_CYCLES - 1));
  assign abort   = abort_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    abort_d  = abort_q;
    // RUN always precedes WAIT, so clearing here restarts the count on each WAIT entry
    if (state_q == StRun) begin
      to_cnt_d = '0;
    end else if (state_q == StWait) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
    if (state_q == StLoad) begin
      abort_d = 1'b0;
    end else if (timeout) begin
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      abort_q  <= abort_d;
    end
  end
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
  assign timeout          = 1'b0;
  assign abort            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    stride_d    = stride_q;
    kernel_d    = kernel_q;
    o_side_d    = o_side_q;
    o_channel_d = o_channel_q;
    ksize_d     = ksize_q;
    stride2_d   = stride2_q;
    n_grp_d     = n_grp_q;
    row_d       = row_q;
    grp_d       = grp_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = bus.cmd_op;
          stride_d    = bus.cmd_stride;
          kernel_d    = bus.cmd_kernel;
          o_side_d    = bus.cmd_o_side;
          o_channel_d = bus.cmd_o_channel;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        ksize_d   = kernel_q * kernel_q;
        stride2_d = 16'(kernel_q) * 16'(stride_q);
        n_grp_d   = n_grp_new;
        row_d     = '0;
        grp_d     = '0;
        if (!op_legal) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (o_side_q == 8'd0 || n_grp_new == 16'd0) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus.eng_done) begin
          state_d = StClr;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StClr;
        end
      end
      StClr: begin
        if (abort) begin
          state_d = StDone;
        end else if (grp_q == n_grp_q - 16'd1) begin
          if (row_q == o_side_q - 8'd1) begin
            state_d = StDone;
          end else begin
            grp_d   = '0;
            row_d   = row_q + 8'd1;
            state_d = StRun;
          end
        end else begin
          grp_d   = grp_q + 16'd1;
          state_d = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered so cmd_ready stays low through reset and rises on the first clock after it
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      op_q        <= '0;
      stride_q    <= '0;
      kernel_q    <= '0;
      o_side_q    <= '0;
      o_channel_q <= '0;
      ksize_q     <= '0;
      stride2_q   <= '0;
      n_grp_q     <= '0;
      row_q       <= '0;
      grp_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      op_q        <= op_d;
      stride_q    <= stride_d;
      kernel_q    <= kernel_d;
      o_side_q    <= o_side_d;
      o_channel_q <= o_channel_d;
      ksize_q     <= ksize_d;
      stride2_q   <= stride2_d;
      n_grp_q     <= n_grp_d;
      row_q       <= row_d;
      grp_q       <= grp_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.eng_valid       = (state_q == StRun) || (state_q == StWait);
  assign bus.eng_clr         = (state_q == StClr);
  assign bus.eng_op          = op_q;
  assign bus.eng_kernel_size = ksize_q;
  assign bus.eng_stride2     = stride2_q;
  assign layer_done          = (state_q == StDone);
  assign row_idx             = row_q;
  assign grp_idx             = grp_q;
  assign err                 = err_q;

endmodule

// File: doc/engine_sched.md
ENGINE_SCHED -- requirements
Module: engine_sched

Interface
REQ-001 Parameter BURST, default 8: channels processed per engine pass.
REQ-002 Parameter TO_CYCLES, default 1048576: watchdog limit in cycles (used only when SCHED_TIMEOUT_EN is defined).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  layer descriptor present.
REQ-006 cmd_ready  output  1  scheduler can accept a descriptor.
REQ-007 cmd_op  input  3  1=CONV, 2=MPOOL, 3=APOOL; other values illegal.
REQ-008 cmd_stride  input  4  stride.
REQ-009 cmd_kernel  input  8  kernel side.
REQ-010 cmd_o_side  input  8  output rows in the layer.
REQ-011 cmd_o_channel  input  16  output channels.
REQ-012 eng_valid  output  1  pass request to the engine.
REQ-013 eng_op  output  3  latched op type.
REQ-014 eng_kernel_size  output  8  kernel*kernel, low 8 bits.
REQ-015 eng_stride2  output  16  kernel*stride.
REQ-016 eng_done  input  1  one-cycle pulse: engine finished the current pass.
REQ-017 eng_clr  output  1  one-cycle pulse: return engine to idle between passes.
REQ-018 row_idx  output  8  current output row.
REQ-019 grp_idx  output  16  current output-channel group.
REQ-020 layer_done  output  1  one-cycle pulse: all passes complete.
REQ-021 err  output  1  sticky error flag; cleared only by reset.

Function
REQ-022 States: IDLE, LOAD, RUN, WAIT, CLR, DONE.
REQ-023 IDLE: cmd_ready=1; cmd_valid=1 latches every cmd_* field, then goes to LOAD.
REQ-024 cmd_ready SHALL be 0 in every state except IDLE; no descriptor is accepted while busy.
REQ-025 LOAD (one cycle): eng_kernel_size, eng_stride2 and n_grp are computed and registered; row_idx=0, grp_idx=0.
REQ-026 n_grp = ceil(cmd_o_channel/BURST) for CONV and 1 for MPOOL/APOOL, 16-bit.
REQ-027 LOAD exits to DONE when the op is illegal (err set to 1), when o_side=0, or when n_grp=0. Otherwise it exits to RUN.
REQ-028 RUN: eng_valid=1 for exactly one cycle, then WAIT.
REQ-029 WAIT: eng_valid stays 1 until eng_done is seen. On eng_done the state goes to CLR and eng_valid drops the next cycle.
REQ-030 An eng_done outside WAIT SHALL be ignored.
REQ-031 CLR: eng_clr=1 for one cycle. Advance order: grp_idx increments first. At grp_idx = n_grp-1, grp_idx wraps to 0 and row_idx increments.
REQ-032 At the CLR after the last pass (row_idx = o_side-1, grp_idx = n_grp-1) the state goes to DONE. Otherwise it goes to RUN.
REQ-033 Total passes = o_side*n_grp. The first eng_valid rises 2 cycles after command acceptance.
REQ-034 Gap from eng_done to the next eng_valid: 2 cycles.
REQ-035 DONE: layer_done=1 for one cycle, then IDLE.
REQ-036 eng_op, eng_kernel_size and eng_stride2 SHALL hold stable from LOAD until the next acceptance.

Reset
REQ-037 On rst, regardless of state: state=IDLE and every output = 0, except cmd_ready. cmd_ready takes 1 on the first clock after rst deasserts.
REQ-038 rst mid-layer discards the latched descriptor. No layer_done or eng_clr SHALL be emitted for the aborted layer.

Configuration
REQ-039 Macro SCHED_TIMEOUT_EN, defined: a counter runs in WAIT and clears on entry to WAIT. When it reaches TO_CYCLES without eng_done: err=1, eng_clr pulses, state goes to DONE (layer_done pulses).
REQ-040 SCHED_TIMEOUT_EN, undefined: no counter exists and WAIT waits indefinitely.

Verification
REQ-041 CONV, kernel=3, stride=1, o_side=4, o_channel=16, eng_done 5 cycles after each eng_valid rise -> 8 passes; (row,grp) sequence (0,0),(0,1),(1,0)..(3,1); kernel_size=9, stride2=3; one layer_done; err=0.
REQ-042 MPOOL, kernel=2, stride=2, o_side=3, o_channel=64 -> n_grp=1, 3 passes, stride2=4, kernel_size=4.
REQ-043 cmd_op=5 -> no eng_valid, err=1, layer_done 2 cycles after acceptance. o_side=0 with op=1 -> layer_done, err=0, no passes.
REQ-044 cmd_valid held high during a layer -> cmd_ready=0 and no second acceptance until after layer_done; a stray eng_done in CLR is ignored.
REQ-045 rst asserted in WAIT -> outputs 0 asynchronously; no layer_done; a new command afterwards runs normally.
REQ-046 SCHED_TIMEOUT_EN defined, TO_CYCLES=16, eng_done never pulsed -> err=1 and eng_clr after 16 WAIT cycles, then layer_done.
